// File: rtl/run_detector_onehot_if.sv
// Bus bundle for the one-hot run detector: sample/control inputs towards the
// detector and its state/flag outputs back towards the consumer.
interface run_detector_onehot_if #(
    parameter int RUN_LEN = 2,
    parameter int CNT_W   = 8
);
    logic                 w;
    logic                 en;
    logic [1:0]           mode;
    logic                 clr;
    logic [2*RUN_LEN:0]   states;
    logic                 z;
    logic                 z_pulse;
    logic [CNT_W-1:0]     hit_count;
    logic                 err;

    // Driver side (stimulus / upstream logic)
    modport master (
        output w, en, mode, clr,
        input  states, z, z_pulse, hit_count, err
    );

    // Detector side
    modport slave (
        input  w, en, mode, clr,
        output states, z, z_pulse, hit_count, err
    );
endinterface

// File: rtl/run_detector_onehot.sv
// One-hot Moore FSM that detects RUN_LEN identical consecutive samples of w.
// State vector: bit0 = INIT, bits[1..RUN_LEN] = Z1..ZRUN_LEN (zeros seen),
// bits[RUN_LEN+1..2*RUN_LEN] = O1..ORUN_LEN (ones seen). A non-one-hot vector
// is recovered to INIT on the next edge and flagged in a sticky err bit.
module run_detector_onehot #(
    parameter int RUN_LEN = 2,
    parameter int CNT_W   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    run_detector_onehot_if.slave  bus
);
    localparam int SW = 2 * RUN_LEN + 1;
    localparam int ZS = RUN_LEN;        // saturated zero-run state index
    localparam int OS = 2 * RUN_LEN;    // saturated one-run state index

    localparam logic [SW-1:0]    ST_INIT  = {{(SW-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        MODE_BOTH = 2'b00,
        MODE_ZERO = 2'b01,
        MODE_ONE  = 2'b10,
        MODE_OFF  = 2'b11
    } mode_e;

    logic [SW-1:0]    r_states;
    logic             r_z_pulse;
    logic [CNT_W-1:0] r_hit;
    logic             r_err;

    logic [SW-1:0]    w_next;
    logic             w_legal;
    logic             w_zero_en;
    logic             w_one_en;
    logic             w_pulse;

    // Exactly one bit set means the state vector is a legal one-hot code.
    function automatic logic is_onehot(input logic [SW-1:0] v);
        int unsigned n;
        n = 32'd0;
        for (int i = 0; i < SW; i++) begin
            n = n + 32'(v[i]);
        end
        return (n == 32'd1);
    endfunction

    assign w_legal = is_onehot(r_states);

    // Decode which run polarities are allowed to report a detection.
    always_comb begin
        w_zero_en = 1'b0;
        w_one_en  = 1'b0;
        case (mode_e'(bus.mode))
            MODE_BOTH: begin w_zero_en = 1'b1; w_one_en = 1'b1; end
            MODE_ZERO: begin w_zero_en = 1'b1; w_one_en = 1'b0; end
            MODE_ONE:  begin w_zero_en = 1'b0; w_one_en = 1'b1; end
            MODE_OFF:  begin w_zero_en = 1'b0; w_one_en = 1'b0; end
            default:   begin w_zero_en = 1'b0; w_one_en = 1'b0; end
        endcase
    end

    // Next one-hot vector: each flop's D is the OR of its predecessors for the current w.
    always_comb begin
        w_next = '0;
        if (bus.w == 1'b0) begin
            w_next[1] = r_states[0] | (|r_states[OS:ZS+1]);
            for (int k = 2; k < RUN_LEN; k++) begin
                w_next[k] = r_states[k-1];
            end
            w_next[ZS] = r_states[ZS-1] | r_states[ZS];
        end else begin
            w_next[RUN_LEN+1] = r_states[0] | (|r_states[ZS:1]);
            for (int k = 2; k < RUN_LEN; k++) begin
                w_next[RUN_LEN+k] = r_states[RUN_LEN+k-1];
            end
            w_next[OS] = r_states[OS-1] | r_states[OS];
        end
    end

    // Pulse only on the edge that enters a saturated state from elsewhere.
    assign w_pulse = bus.en & w_legal &
                     ((w_next[ZS] & ~r_states[ZS] & w_zero_en) |
                      (w_next[OS] & ~r_states[OS] & w_one_en));

    // State, pulse, hit counter and sticky error registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_states  <= ST_INIT;
            r_z_pulse <= 1'b0;
            r_hit     <= '0;
            r_err     <= 1'b0;
        end else begin
            if (!w_legal) begin
                r_states  <= ST_INIT;
                r_z_pulse <= 1'b0;
            end else if (bus.en) begin
                r_states  <= w_next;
                r_z_pulse <= w_pulse;
            end else begin
                r_states  <= r_states;
                r_z_pulse <= 1'b0;
            end

            if (bus.clr) begin
                r_hit <= '0;
            end else if (w_pulse && (r_hit != CNT_MAX)) begin
                r_hit <= r_hit + CNT_ONE;
            end else begin
                r_hit <= r_hit;
            end

            // Detecting a corrupted state takes precedence over a clear.
            if (!w_legal) begin
                r_err <= 1'b1;
            end else if (bus.clr) begin
                r_err <= 1'b0;
            end else begin
                r_err <= r_err;
            end
        end
    end

    assign bus.states    = r_states;
    assign bus.z         = (r_states[ZS] & w_zero_en) | (r_states[OS] & w_one_en);
    assign bus.z_pulse   = r_z_pulse;
    assign bus.hit_count = r_hit;
    assign bus.err       = r_err;
endmodule
